// File: rtl/fsa_ppbuf_pool_if.sv
// fsa_ppbuf_pool_if
//  Bundles the writer and reader signals of the FSA frame-buffer pool.
//  master: producer/consumer side (fsa_core writer plus the frame readers).
//  slave : the pool itself.
// Signals
//  w_sof, w_en, w_addr, w_data    writer strobes, address and data
//  w_bmp                          one-hot buffer owned by the writer
//  r_sof, r_en, r_addr            per-reader strobes and packed addresses
//  r_data, r_bmp, r_coll          per-reader packed data, held buffer, collision flag
interface fsa_ppbuf_pool_if #(
  parameter int C_BUFF_NUM = 4,
  parameter int C_RD_NUM   = 2,
  parameter int BR_AW      = 12,
  parameter int BR_DW      = 51
);
  logic                           w_sof;
  logic                           w_en;
  logic [BR_AW-1:0]               w_addr;
  logic [BR_DW-1:0]               w_data;
  logic [C_BUFF_NUM-1:0]          w_bmp;
  logic [C_RD_NUM-1:0]            r_sof;
  logic [C_RD_NUM-1:0]            r_en;
  logic [C_RD_NUM*BR_AW-1:0]      r_addr;
  logic [C_RD_NUM*BR_DW-1:0]      r_data;
  logic [C_RD_NUM*C_BUFF_NUM-1:0] r_bmp;
  logic [C_RD_NUM-1:0]            r_coll;

  modport master (
    output w_sof, w_en, w_addr, w_data, r_sof, r_en, r_addr,
    input  w_bmp, r_data, r_bmp, r_coll
  );

  modport slave (
    input  w_sof, w_en, w_addr, w_data, r_sof, r_en, r_addr,
    output w_bmp, r_data, r_bmp, r_coll
  );
endinterface

// File: rtl/fsa_ppbuf_pool.sv
// fsa_ppbuf_pool
//  Frame-buffer pool for FSA per-column profile data. C_BUFF_NUM block RAMs shared by one
//  writer and C_RD_NUM frame readers. The writer always owns a private buffer; at its SOF
//  a reader switches to the newest complete frame ('latest'). Reads have a 3-cycle latency;
//  readers hitting the same RAM in the same cycle share the lowest-index reader's data and
//  the losers flag r_coll.
// Ports
//  clk       clock
//  resetn    asynchronous active-low reset
//  bus       fsa_ppbuf_pool_if.slave (writer and reader signals)
//  coll_cnt  [15:0] saturating collision counter, present only with FSA_PPBUF_COLL_CNT_EN
// Configuration macro: FSA_PPBUF_COLL_CNT_EN
module fsa_ppbuf_pool #(
  parameter int C_BUFF_NUM = 4,
  parameter int C_RD_NUM   = 2,
  parameter int BR_AW      = 12,
  parameter int BR_DW      = 51
) (
  input  logic              clk,
  input  logic              resetn,
  fsa_ppbuf_pool_if.slave   bus
`ifdef FSA_PPBUF_COLL_CNT_EN
  ,
  output logic [15:0]       coll_cnt
`endif
);

  localparam int BI_W      = (C_BUFF_NUM > 1) ? $clog2(C_BUFF_NUM) : 1;
  localparam int RAM_DEPTH = 1 << BR_AW;

  if (C_BUFF_NUM < C_RD_NUM + 2) begin : g_bad_buff_num
    $error("fsa_ppbuf_pool: C_BUFF_NUM must be >= C_RD_NUM + 2");
  end
  if (C_RD_NUM < 1 || C_RD_NUM > 8) begin : g_bad_rd_num
    $error("fsa_ppbuf_pool: C_RD_NUM must be in 1..8");
  end

  function automatic logic [BI_W-1:0] oh2idx(input logic [C_BUFF_NUM-1:0] oh);
    logic [BI_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < C_BUFF_NUM; i++) begin
      if (oh[i]) idx = idx | BI_W'(i);
    end
    return idx;
  endfunction

  // Ownership state; latest == 0 means no frame has been committed yet.
  logic [C_BUFF_NUM-1:0] w_own, w_own_nxt;
  logic [C_BUFF_NUM-1:0] latest, latest_nxt;
  logic [C_BUFF_NUM-1:0] rd_own     [C_RD_NUM];
  logic [C_BUFF_NUM-1:0] rd_own_nxt [C_RD_NUM];
  logic [C_BUFF_NUM-1:0] held_nxt, free_nxt;

  // The write commit is resolved first so a reader with a concurrent SOF picks up the
  // buffer that was just finished; the writer then avoids everything held afterwards.
  always_comb begin
    latest_nxt = bus.w_sof ? w_own : latest;
    held_nxt   = '0;
    for (int k = 0; k < C_RD_NUM; k++) begin
      rd_own_nxt[k] = bus.r_sof[k] ? latest_nxt : rd_own[k];
      held_nxt      = held_nxt | rd_own_nxt[k];
    end
    free_nxt  = ~(held_nxt | latest_nxt);
    w_own_nxt = w_own;
    if (bus.w_sof) begin
      w_own_nxt = '0;
      for (int i = C_BUFF_NUM - 1; i >= 0; i--) begin
        if (free_nxt[i]) begin
          w_own_nxt    = '0;
          w_own_nxt[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_own  <= {{(C_BUFF_NUM-1){1'b0}}, 1'b1};
      latest <= '0;
      for (int k = 0; k < C_RD_NUM; k++) rd_own[k] <= '0;
    end else begin
      w_own  <= w_own_nxt;
      latest <= latest_nxt;
      for (int k = 0; k < C_RD_NUM; k++) rd_own[k] <= rd_own_nxt[k];
    end
  end

  a_free_buf: assert property (@(posedge clk) disable iff (!resetn) bus.w_sof |-> (|free_nxt));

  // One read port per RAM: scanning readers from high to low index leaves the lowest
  // requesting reader in control of each RAM's address.
  logic [C_BUFF_NUM-1:0] ram_req;
  logic [BR_AW-1:0]      ram_req_addr [C_BUFF_NUM];
  logic [C_RD_NUM-1:0]   rd_coll_nxt;

  always_comb begin
    ram_req     = '0;
    rd_coll_nxt = '0;
    for (int b = 0; b < C_BUFF_NUM; b++) begin
      ram_req_addr[b] = '0;
      for (int k = C_RD_NUM - 1; k >= 0; k--) begin
        if (bus.r_en[k] && rd_own[k][b]) begin
          ram_req[b]      = 1'b1;
          ram_req_addr[b] = bus.r_addr[k*BR_AW +: BR_AW];
        end
      end
    end
    for (int k = 1; k < C_RD_NUM; k++) begin
      for (int j = 0; j < k; j++) begin
        if (bus.r_en[k] && bus.r_en[j] && (|(rd_own[k] & rd_own[j]))) rd_coll_nxt[k] = 1'b1;
      end
    end
  end

  // Pipeline: stage 1 registers the RAM address and per-reader routing, stage 2 is the
  // RAM output register, stage 3 steers the selected RAM output into r_data.
  logic [C_BUFF_NUM-1:0] ram_en_q;
  logic [BR_AW-1:0]      ram_addr_q [C_BUFF_NUM];
  logic [BR_DW-1:0]      ram_dout   [C_BUFF_NUM];
  logic [C_RD_NUM-1:0]   rd_vld1, rd_hit1, rd_coll1;
  logic [C_RD_NUM-1:0]   rd_vld2, rd_hit2, rd_coll2;
  logic [BI_W-1:0]       rd_idx1 [C_RD_NUM];
  logic [BI_W-1:0]       rd_idx2 [C_RD_NUM];
  logic [BR_DW-1:0]      r_data_q [C_RD_NUM];
  logic [C_RD_NUM-1:0]   r_coll_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_en_q <= '0;
      rd_vld1  <= '0;
      rd_hit1  <= '0;
      rd_coll1 <= '0;
      rd_vld2  <= '0;
      rd_hit2  <= '0;
      rd_coll2 <= '0;
      r_coll_q <= '0;
      for (int b = 0; b < C_BUFF_NUM; b++) ram_addr_q[b] <= '0;
      for (int k = 0; k < C_RD_NUM; k++) begin
        rd_idx1[k]  <= '0;
        rd_idx2[k]  <= '0;
        r_data_q[k] <= '0;
      end
    end else begin
      ram_en_q <= ram_req;
      for (int b = 0; b < C_BUFF_NUM; b++) ram_addr_q[b] <= ram_req_addr[b];
      rd_vld1  <= bus.r_en;
      rd_coll1 <= rd_coll_nxt;
      rd_vld2  <= rd_vld1;
      rd_hit2  <= rd_hit1;
      rd_coll2 <= rd_coll1;
      r_coll_q <= rd_vld2 & rd_coll2;
      for (int k = 0; k < C_RD_NUM; k++) begin
        rd_hit1[k] <= |rd_own[k];
        rd_idx1[k] <= oh2idx(rd_own[k]);
        rd_idx2[k] <= rd_idx1[k];
        if (rd_vld2[k]) r_data_q[k] <= rd_hit2[k] ? ram_dout[rd_idx2[k]] : '0;
      end
    end
  end

  // RAM arrays and their output registers carry no reset so they map onto block RAM;
  // contents survive reset and become reachable again after the next committed frame.
  logic [BR_DW-1:0] mem [C_BUFF_NUM][RAM_DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < C_BUFF_NUM; b++) begin
      if (resetn && bus.w_en && w_own[b]) mem[b][bus.w_addr] <= bus.w_data;
      if (ram_en_q[b]) ram_dout[b] <= mem[b][ram_addr_q[b]];
    end
  end

  assign bus.w_bmp  = w_own;
  assign bus.r_coll = r_coll_q;

  for (genvar k = 0; k < C_RD_NUM; k++) begin : g_out
    assign bus.r_bmp[k*C_BUFF_NUM +: C_BUFF_NUM] = rd_own[k];
    assign bus.r_data[k*BR_DW +: BR_DW]          = r_data_q[k];
  end

`ifdef FSA_PPBUF_COLL_CNT_EN
  logic [16:0] coll_sum;

  always_comb coll_sum = {1'b0, coll_cnt} + 17'($countones(r_coll_q));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      coll_cnt <= '0;
    end else if (bus.w_sof) begin
      coll_cnt <= '0;
    end else begin
      coll_cnt <= coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fsa_ppbuf_pool.sv
// tb_fsa_ppbuf_pool
//  Directed bench for fsa_ppbuf_pool (6 buffers, 4 readers). Reads push their expected
//  data/collision into a scoreboard; a monitor pops and compares when the read emerges.
//  Ownership (w_bmp/r_bmp) is compared against a small index-based reference model.
module tb_fsa_ppbuf_pool;
  localparam int NB = 6;
  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 51;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fsa_ppbuf_pool_if #(.C_BUFF_NUM(NB), .C_RD_NUM(NR), .BR_AW(AW), .BR_DW(DW)) bus ();

`ifdef FSA_PPBUF_COLL_CNT_EN
  logic [15:0] coll_cnt;
`endif

  fsa_ppbuf_pool #(.C_BUFF_NUM(NB), .C_RD_NUM(NR), .BR_AW(AW), .BR_DW(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef FSA_PPBUF_COLL_CNT_EN
    ,
    .coll_cnt (coll_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference ownership model: buffer indices, -1 = none.
  int m_w;
  int m_latest;
  int m_r [NR];

  typedef struct {
    int            k;
    logic [DW-1:0] d;
    logic          c;
  } exp_t;
  exp_t sb [$];

  logic [NR-1:0] en_d1, en_d2, en_d3;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] oh(input int i);
    logic [NB-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cycle();
    bus.w_en  = 1'b0;
    bus.w_sof = 1'b0;
    bus.r_sof = '0;
    bus.r_en  = '0;
  endtask

  task automatic clear_inputs();
    bus.w_sof  = 1'b0;
    bus.w_en   = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    bus.r_sof  = '0;
    bus.r_en   = '0;
    bus.r_addr = '0;
  endtask

  task automatic model_reset();
    m_w = 0;
    m_latest = -1;
    for (int k = 0; k < NR; k++) m_r[k] = -1;
  endtask

  task automatic model_sof(input bit wsof, input logic [NR-1:0] rsof);
    bit found;
    bit busy;
    if (wsof) m_latest = m_w;
    for (int k = 0; k < NR; k++) if (rsof[k]) m_r[k] = m_latest;
    if (wsof) begin
      found = 1'b0;
      for (int i = 0; i < NB; i++) begin
        busy = (i == m_latest);
        for (int k = 0; k < NR; k++) if (m_r[k] == i) busy = 1'b1;
        if (!busy && !found) begin
          m_w = i;
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic check_own(input string tag);
    check_output({tag, "_w_bmp"}, 64'(bus.w_bmp), 64'(oh(m_w)));
    for (int k = 0; k < NR; k++)
      check_output($sformatf("%s_r_bmp%0d", tag, k), 64'(bus.r_bmp[k*NB +: NB]), 64'(oh(m_r[k])));
  endtask

  task automatic apply_sof(input string tag, input bit wsof, input logic [NR-1:0] rsof);
    bus.w_sof = wsof;
    bus.r_sof = rsof;
    step();
    model_sof(wsof, rsof);
    check_own(tag);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.w_en   = 1'b1;
    bus.w_addr = a;
    bus.w_data = d;
    step();
  endtask

  task automatic queue_read(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
    exp_t e;
    e.k = k;
    e.d = d;
    e.c = c;
    bus.r_en[k] = 1'b1;
    bus.r_addr[k*AW +: AW] = a;
    sb.push_back(e);
  endtask

  task automatic drain();
    repeat (4) cycle();
  endtask

  // Read-valid tracking: a read issued at one edge is due three edges later.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_d1 <= '0;
      en_d2 <= '0;
      en_d3 <= '0;
    end else begin
      en_d1 <= bus.r_en;
      en_d2 <= en_d1;
      en_d3 <= en_d2;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn) begin
      for (int k = 0; k < NR; k++) begin
        if (en_d3[k]) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_underflow reader=%0d actual=empty expected=entry", k);
          end else begin
            e = sb.pop_front();
            check_output($sformatf("r_data%0d", k), 64'(bus.r_data[k*DW +: DW]), 64'(e.d));
            check_output($sformatf("r_coll%0d", k), 64'(bus.r_coll[k]), 64'(e.c));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [NB-1:0] held;
    clear_inputs();
    model_reset();
    repeat (3) cycle();
    resetn = 1'b1;
    #1;

    // Reset state
    check_output("rst_w_bmp", 64'(bus.w_bmp), 64'h1);
    check_output("rst_r_coll", 64'(bus.r_coll), 64'h0);
    for (int k = 0; k < NR; k++) begin
      check_output($sformatf("rst_r_bmp%0d", k), 64'(bus.r_bmp[k*NB +: NB]), 64'h0);
      check_output($sformatf("rst_r_data%0d", k), 64'(bus.r_data[k*DW +: DW]), 64'h0);
    end

    // Reader SOF before any frame: no buffer, reads return zero
    apply_sof("early_rsof", 1'b0, 4'b0001);
    queue_read(0, 12'd5, '0, 1'b0);
    step();
    drain();

    // First frame into buf0, commit, reader0 picks it up
    write_word(12'd5, 51'h1234);
    apply_sof("commit0", 1'b1, 4'b0000);
    apply_sof("r0_take", 1'b0, 4'b0001);
    queue_read(0, 12'd5, 51'h1234, 1'b0);
    step();
    drain();
    check_output("r_data0_hold", 64'(bus.r_data[0 +: DW]), 64'h1234);

    // Concurrent w_sof and r_sof[1]: reader1 gets the just-written buf1
    write_word(12'd7, 51'hABCD);
    apply_sof("wsof_rsof1", 1'b1, 4'b0010);
    queue_read(1, 12'd7, 51'hABCD, 1'b0);
    step();
    drain();

    // Readers 0 and 1 share buf1: collisions resolve toward reader0
    apply_sof("r0_share", 1'b0, 4'b0001);
    queue_read(0, 12'd7, 51'hABCD, 1'b0);
    queue_read(1, 12'd7, 51'hABCD, 1'b1);
    queue_read(2, 12'd5, '0, 1'b0);
    step();
    queue_read(0, 12'd7, 51'hABCD, 1'b0);
    queue_read(1, 12'd5, 51'hABCD, 1'b1);
    step();
    queue_read(1, 12'd7, 51'hABCD, 1'b0);
    step();
    drain();

    // r_sof concurrent with r_en: read still comes from the old buffer
    write_word(12'd7, 51'h5555);
    apply_sof("commit2", 1'b1, 4'b0000);
    queue_read(0, 12'd7, 51'hABCD, 1'b0);
    apply_sof("r0_sof_rd", 1'b0, 4'b0001);
    queue_read(0, 12'd7, 51'h5555, 1'b0);
    step();
    drain();

    // Three readers pinned on distinct buffers, writer keeps rotating
    apply_sof("pin_r2", 1'b1, 4'b0100);
    for (int i = 0; i < 20; i++) begin
      apply_sof($sformatf("rot%0d", i), 1'b1, (i % 5 == 4) ? 4'b1000 : 4'b0000);
      held = '0;
      for (int k = 0; k < NR; k++) held = held | bus.r_bmp[k*NB +: NB];
      check_output($sformatf("rot%0d_overlap", i), 64'(bus.w_bmp & held), 64'h0);
    end

    // Reset in the middle of a read burst
    for (int j = 0; j < 4; j++) begin
      queue_read(0, 12'd7, 51'h5555, 1'b0);
      step();
    end
    queue_read(0, 12'd7, 51'h5555, 1'b0);
    #3;
    resetn = 1'b0;
    #2;
    check_output("mid_rst_r_data0", 64'(bus.r_data[0 +: DW]), 64'h0);
    check_output("mid_rst_r_coll", 64'(bus.r_coll), 64'h0);
    check_output("mid_rst_w_bmp", 64'(bus.w_bmp), 64'h1);
    check_output("mid_rst_r_bmp", 64'(bus.r_bmp), 64'h0);
    sb.delete();
    clear_inputs();
    model_reset();
    repeat (2) cycle();
    resetn = 1'b1;
    #1;

    // Old contents are unreachable until a new frame is committed
    apply_sof("post_rst_rsof", 1'b0, 4'b0001);
    queue_read(0, 12'd7, '0, 1'b0);
    step();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
